// File: rtl/sech2_arg_scaler.sv
// Joins x and g streams, computes (x - g) * scale, then rounds and saturates to the LUT address format.
// Latency: 3 cycles from join acceptance to m_axis_0_tvalid; one beat per cycle per channel.
// Backpressure: per-stage ready chain (ready_k = !valid_k || ready_k+1), so each channel holds 3 beats under stall.
module sech2_arg_scaler #(
  parameter int DATA_WIDTH_DATA       = 16,
  parameter int FRACTIONAL_BITS_DATA  = 12,
  parameter int DATA_WIDTH_SCALE      = 16,
  parameter int FRACTIONAL_BITS_SCALE = 12,
  parameter int DATA_WIDTH_RSLT       = 16,
  parameter int FRACTIONAL_BITS_RSLT  = 12,
  parameter int CHANNELS              = 1,
  parameter int ID_ENABLE             = 0,
  parameter int ID_WIDTH              = 8,
  parameter int DEST_ENABLE           = 0,
  parameter int DEST_WIDTH            = 8,
  parameter int USER_ENABLE           = 0,
  parameter int USER_WIDTH            = 1
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [CHANNELS*DATA_WIDTH_DATA-1:0]           s_axis_data_tdata,
  input  logic [CHANNELS-1:0]                           s_axis_data_tvalid,
  input  logic [CHANNELS-1:0]                           s_axis_data_tlast,
  output logic [CHANNELS-1:0]                           s_axis_data_tready,
  input  logic [CHANNELS*ID_WIDTH-1:0]                  s_axis_data_tid,
  input  logic [CHANNELS*DEST_WIDTH-1:0]                s_axis_data_tdest,
  input  logic [CHANNELS*USER_WIDTH-1:0]                s_axis_data_tuser,
  input  logic [CHANNELS*DATA_WIDTH_DATA-1:0]           s_axis_grid_tdata,
  input  logic [CHANNELS-1:0]                           s_axis_grid_tvalid,
  input  logic [CHANNELS-1:0]                           s_axis_grid_tlast,
  output logic [CHANNELS-1:0]                           s_axis_grid_tready,
  input  logic [CHANNELS*DATA_WIDTH_SCALE-1:0]          scale_data,
  input  logic [CHANNELS-1:0]                           scale_load,
  output logic [CHANNELS*DATA_WIDTH_RSLT-1:0]           m_axis_0_tdata,
  output logic [CHANNELS*((DATA_WIDTH_RSLT+7)/8)-1:0]   m_axis_0_tkeep,
  output logic [CHANNELS-1:0]                           m_axis_0_tvalid,
  output logic [CHANNELS-1:0]                           m_axis_0_tlast,
  input  logic [CHANNELS-1:0]                           m_axis_0_tready,
  output logic [CHANNELS*ID_WIDTH-1:0]                  m_axis_0_tid,
  output logic [CHANNELS*DEST_WIDTH-1:0]                m_axis_0_tdest,
  output logic [CHANNELS*USER_WIDTH-1:0]                m_axis_0_tuser,
  output logic [CHANNELS-1:0]                           err_tlast_mismatch
);

  localparam int DW  = DATA_WIDTH_DATA;
  localparam int DW1 = DATA_WIDTH_DATA + 1;
  localparam int DWS = DATA_WIDTH_SCALE;
  localparam int DWR = DATA_WIDTH_RSLT;
  localparam int PW  = DATA_WIDTH_DATA + 1 + DATA_WIDTH_SCALE;
  localparam int SH  = FRACTIONAL_BITS_DATA + FRACTIONAL_BITS_SCALE - FRACTIONAL_BITS_RSLT;
  // One extra bit over the product absorbs the rounding increment; never narrower than the result plus sign.
  localparam int SW  = (PW + 1 > DWR + 1) ? PW + 1 : DWR + 1;

  localparam logic signed [DWS-1:0] SCALE_ONE = DWS'(1) << FRACTIONAL_BITS_SCALE;
  localparam logic signed [SW-1:0]  HALF      = (SH > 0) ? (SW'(1) << ((SH > 0) ? SH - 1 : 0)) : SW'(0);
  localparam logic signed [SW-1:0]  MAXV      = {{(SW-DWR+1){1'b0}}, {(DWR-1){1'b1}}};
  localparam logic signed [SW-1:0]  MINV      = {{(SW-DWR+1){1'b1}}, {(DWR-1){1'b0}}};

  // Sideband travelling alongside each beat; disabled fields are zeroed at capture.
  typedef struct packed {
    logic                  last;
    logic [ID_WIDTH-1:0]   id;
    logic [DEST_WIDTH-1:0] dest;
    logic [USER_WIDTH-1:0] user;
  } sb_t;

  assign m_axis_0_tkeep = '1;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic                   v1, v2, v3;
    logic                   rdy0, rdy1, rdy2;
    logic                   acc;
    logic signed [DW-1:0]   x, g;
    logic signed [DW:0]     d1;
    logic signed [PW-1:0]   p2;
    logic [DWR-1:0]         q3, q_nxt;
    logic signed [SW-1:0]   pe, sh;
    logic signed [DWS-1:0]  scale_q;
    sb_t                    sb_in, sb1, sb2, sb3;

    assign x = s_axis_data_tdata[c*DW +: DW];
    assign g = s_axis_grid_tdata[c*DW +: DW];

    assign sb_in.last = s_axis_data_tlast[c];
    assign sb_in.id   = (ID_ENABLE   != 0) ? s_axis_data_tid[c*ID_WIDTH +: ID_WIDTH]       : '0;
    assign sb_in.dest = (DEST_ENABLE != 0) ? s_axis_data_tdest[c*DEST_WIDTH +: DEST_WIDTH] : '0;
    assign sb_in.user = (USER_ENABLE != 0) ? s_axis_data_tuser[c*USER_WIDTH +: USER_WIDTH] : '0;

    assign rdy2 = !v3 || m_axis_0_tready[c];
    assign rdy1 = !v2 || rdy2;
    assign rdy0 = !v1 || rdy1;

    // Both streams are consumed together; nothing is taken while reset is asserted.
    assign acc                   = s_axis_data_tvalid[c] && s_axis_grid_tvalid[c] && rdy0 && !rst;
    assign s_axis_data_tready[c] = rdy0 && s_axis_grid_tvalid[c] && !rst;
    assign s_axis_grid_tready[c] = rdy0 && s_axis_data_tvalid[c] && !rst;
    assign err_tlast_mismatch[c] = acc && (s_axis_data_tlast[c] != s_axis_grid_tlast[c]);

    // Scale register, reset to 1.0 and overwritten whenever a load is presented.
    always_ff @(posedge clk) begin
      if (rst) begin
        scale_q <= SCALE_ONE;
      end else if (scale_load[c]) begin
        scale_q <= scale_data[c*DWS +: DWS];
      end
    end

    // S1: exact difference of the joined pair plus the data-side sideband.
    always_ff @(posedge clk) begin
      if (rst) begin
        v1 <= 1'b0;
      end else if (rdy0) begin
        v1 <= acc;
        if (acc) begin
          d1  <= DW1'(x) - DW1'(g);
          sb1 <= sb_in;
        end
      end
    end

    // S2: exact product with the scale value held at capture time.
    always_ff @(posedge clk) begin
      if (rst) begin
        v2 <= 1'b0;
      end else if (rdy1) begin
        v2 <= v1;
        if (v1) begin
          p2  <= PW'(d1) * PW'(scale_q);
          sb2 <= sb1;
        end
      end
    end

    // Round half toward +inf by adding half an output LSB before the arithmetic shift, then clamp.
    always_comb begin
      pe    = SW'(p2);
      sh    = (pe + HALF) >>> SH;
      q_nxt = sh[DWR-1:0];
      if (sh > MAXV) begin
        q_nxt = MAXV[DWR-1:0];
      end else if (sh < MINV) begin
        q_nxt = MINV[DWR-1:0];
      end
    end

    // S3: registered saturated result; holds steady while the sink stalls.
    always_ff @(posedge clk) begin
      if (rst) begin
        v3 <= 1'b0;
      end else if (rdy2) begin
        v3 <= v2;
        if (v2) begin
          q3  <= q_nxt;
          sb3 <= sb2;
        end
      end
    end

    assign m_axis_0_tdata[c*DWR +: DWR]               = q3;
    assign m_axis_0_tvalid[c]                         = v3;
    assign m_axis_0_tlast[c]                          = sb3.last;
    assign m_axis_0_tid[c*ID_WIDTH +: ID_WIDTH]       = sb3.id;
    assign m_axis_0_tdest[c*DEST_WIDTH +: DEST_WIDTH] = sb3.dest;
    assign m_axis_0_tuser[c*USER_WIDTH +: USER_WIDTH] = sb3.user;
  end

endmodule

// File: tb/tb_sech2_arg_scaler.sv
// Scoreboard bench: the driver pushes modelled results at join acceptance, a monitor pops them at output handshakes.
// Reference is plain integer arithmetic on the fixed-point values (FD=FS=FR=12, 16-bit widths).
// Directed test-plan vectors, backpressure, join skew, mid-stream reset and a randomized run.
module tb_sech2_arg_scaler;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] x, g, scale_data;
  logic        dv, gv, dl, gl, scale_load;
  logic        d_rdy, g_rdy;
  logic [7:0]  id, dest;
  logic        user;
  logic [15:0] m_dat;
  logic [1:0]  m_keep;
  logic        m_vld, m_last, m_rdy, err;
  logic [7:0]  m_id, m_dest;
  logic        m_user;

  always #5 clk = ~clk;

  sech2_arg_scaler #(
    .ID_ENABLE(1), .ID_WIDTH(8), .DEST_ENABLE(0), .DEST_WIDTH(8), .USER_ENABLE(1), .USER_WIDTH(1)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_data_tdata(x), .s_axis_data_tvalid(dv), .s_axis_data_tlast(dl), .s_axis_data_tready(d_rdy),
    .s_axis_data_tid(id), .s_axis_data_tdest(dest), .s_axis_data_tuser(user),
    .s_axis_grid_tdata(g), .s_axis_grid_tvalid(gv), .s_axis_grid_tlast(gl), .s_axis_grid_tready(g_rdy),
    .scale_data(scale_data), .scale_load(scale_load),
    .m_axis_0_tdata(m_dat), .m_axis_0_tkeep(m_keep), .m_axis_0_tvalid(m_vld), .m_axis_0_tlast(m_last),
    .m_axis_0_tready(m_rdy), .m_axis_0_tid(m_id), .m_axis_0_tdest(m_dest), .m_axis_0_tuser(m_user),
    .err_tlast_mismatch(err)
  );

  typedef struct {
    logic [15:0] d;
    logic        last;
    logic [7:0]  id;
    logic        user;
    int          acyc;
    bit          lat;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0, n_err = 0;
  int          cyc = 0;
  logic [15:0] m_scale;
  bit          lat_flag, acc;
  int          acc_cnt = 0, err_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Real-valued meaning: round((x-g)*scale) to 12 fractional bits, ties up, clamp to 16-bit signed.
  function automatic logic [15:0] model(input logic [15:0] xv, input logic [15:0] gv_, input logic [15:0] sv);
    longint d, p, r, qv;
    d  = longint'($signed(xv)) - longint'($signed(gv_));
    p  = d * longint'($signed(sv));
    r  = p + 2048;
    qv = r / 4096;
    if (r < 0 && (r % 4096) != 0) qv = qv - 1;
    if (qv > 32767)  qv = 32767;
    if (qv < -32768) qv = -32768;
    return qv[15:0];
  endfunction

  // One clock: input-side checks and scoreboard push at the negedge, then new drive just after the posedge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    acc = 1'b0;
    if (!rst) begin
      acc = dv && d_rdy;
      if (!gv) chk("data_rdy_without_grid", d_rdy, 0);
      if (!dv) chk("grid_rdy_without_data", g_rdy, 0);
      chk("join_lockstep", dv && d_rdy, gv && g_rdy);
      chk("err_pulse", err, acc && (dl != gl));
      if (err) err_cnt++;
      if (acc) begin
        e.d = model(x, g, m_scale); e.last = dl; e.id = id; e.user = user;
        e.acyc = cyc; e.lat = lat_flag;
        q.push_back(e);
        acc_cnt++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic new_beat();
    x = 16'($urandom); g = 16'($urandom); id = 8'($urandom); dest = 8'($urandom);
    user = 1'($urandom); dl = 1'($urandom); gl = 1'($urandom);
  endtask

  task automatic send1(input logic [15:0] xv, input logic [15:0] gvv, input bit lat);
    int k = 0;
    new_beat();
    x = xv; g = gvv; gl = dl; lat_flag = lat;
    dv = 1'b1; gv = 1'b1;
    do begin step(); k++; end while (!acc && k < 100);
    if (!acc) chk("send_timeout", 0, 1);
    dv = 1'b0; gv = 1'b0; lat_flag = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    m_rdy = 1'b1;
    while (q.size() != 0 && k < 200) begin step(); k++; end
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
  endtask

  task automatic load_scale(input logic [15:0] s);
    drain();
    scale_data = s; scale_load = 1'b1;
    step();
    scale_load = 1'b0;
    m_scale = s;
  endtask

  // Output monitor: pops on every handshake and checks stability of stalled beats.
  initial begin : monitor
    exp_t        e;
    bit          held = 1'b0;
    logic [25:0] held_v = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
      end else begin
        if (held) begin
          chk("stall_vld_held", m_vld, 1);
          chk("stall_payload_stable", {m_dat, m_last, m_id, m_user}, held_v);
        end
        if (m_vld && m_rdy) begin
          if (q.size() == 0) begin
            chk("unexpected_output", m_dat, 0);
            chk("unexpected_output_vld", 1, 0);
          end else begin
            e = q.pop_front();
            chk("tdata", m_dat, e.d);
            chk("tlast", m_last, e.last);
            chk("tid", m_id, e.id);
            chk("tuser", m_user, e.user);
            chk("tdest_disabled", m_dest, 0);
            if (e.lat) chk("latency", cyc - e.acyc, 3);
          end
        end
        held   = m_vld && !m_rdy;
        held_v = {m_dat, m_last, m_id, m_user};
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin : main
    int k, n0, e0;
    rst = 1'b1; dv = 1'b1; gv = 1'b1; x = '0; g = '0; dl = 0; gl = 0;
    id = '0; dest = '0; user = 0; scale_data = '0; scale_load = 1'b0;
    m_rdy = 1'b1; m_scale = 16'h1000; lat_flag = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_tvalid", m_vld, 0);
    chk("rst_err", err, 0);
    chk("rst_data_tready", d_rdy, 0);
    chk("tkeep", m_keep, 2'b11);
    @(posedge clk); #1;
    rst = 1'b0; dv = 1'b0; gv = 1'b0;
    step();

    // Directed vectors from the test plan.
    send1(16'h0000, 16'h1000, 1); drain();
    load_scale(16'h2000);
    send1(16'h1000, 16'h0800, 1); drain();
    send1(16'h7FFF, 16'h8000, 1); drain();
    send1(16'h8000, 16'h7FFF, 1); drain();
    load_scale(16'h0800);
    send1(16'h0001, 16'h0000, 1); drain();
    send1(16'h0000, 16'h0001, 1); drain();

    // Sink stalled from empty: exactly three beats fit.
    load_scale(16'h1000);
    m_rdy = 1'b0; new_beat(); dv = 1'b1; gv = 1'b1;
    n0 = acc_cnt;
    repeat (10) begin step(); if (acc) new_beat(); end
    chk("stall_accept_count", acc_cnt - n0, 3);
    dv = 1'b0; gv = 1'b0;
    drain();

    // Eight-beat stream with the sink stalled during cycles 2..7.
    n0 = acc_cnt; k = 0;
    new_beat(); dv = 1'b1; gv = 1'b1;
    while (acc_cnt - n0 < 8 && k < 100) begin
      m_rdy = !(k >= 2 && k <= 7);
      step(); k++;
      if (acc) new_beat();
    end
    chk("burst8_accepted", acc_cnt - n0, 8);
    dv = 1'b0; gv = 1'b0;
    drain();

    // Grid lags data by four cycles; then a tlast mismatch on the third beat only.
    n0 = acc_cnt; e0 = err_cnt;
    new_beat(); gl = dl; dv = 1'b1; gv = 1'b0;
    repeat (4) step();
    chk("skew_no_accept", acc_cnt - n0, 0);
    gv = 1'b1; k = 0;
    while (acc_cnt - n0 < 5 && k < 100) begin
      step(); k++;
      if (acc) begin
        new_beat();
        gl = (acc_cnt - n0 == 2) ? !dl : dl;
      end
    end
    chk("skew_accepted", acc_cnt - n0, 5);
    chk("skew_err_pulses", err_cnt - e0, 1);
    dv = 1'b0; gv = 1'b0;
    drain();

    // Randomized traffic with random sink stalls and occasional scale reloads between bursts.
    for (int r = 0; r < 4; r++) begin
      load_scale(16'($urandom));
      new_beat();
      for (int i = 0; i < 150; i++) begin
        if (!dv) dv = ($urandom_range(0, 3) != 0);
        if (!gv) gv = ($urandom_range(0, 3) != 0);
        m_rdy = ($urandom_range(0, 3) != 0);
        step();
        if (acc) begin new_beat(); dv = 1'b0; gv = 1'b0; end
      end
      dv = 1'b0; gv = 1'b0;
      drain();
    end

    // Reset with three beats in flight: they vanish and scale returns to 1.0.
    load_scale(16'h2000);
    m_rdy = 1'b0; n0 = acc_cnt; k = 0;
    new_beat(); dv = 1'b1; gv = 1'b1;
    while (acc_cnt - n0 < 3 && k < 50) begin step(); k++; if (acc) new_beat(); end
    chk("inflight_before_reset", acc_cnt - n0, 3);
    dv = 1'b0; gv = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    m_scale = 16'h1000;
    @(negedge clk);
    chk("post_rst_m_tvalid", m_vld, 0);
    @(posedge clk); #1;
    m_rdy = 1'b1;
    repeat (6) step();
    send1(16'h1000, 16'h0000, 1);
    drain();
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
